max_pool_layer: RTL and testbench

MAX_POOL_LAYER -- requirements
Module: max_pool_layer

---
 rtl/cnn_pkg.sv | 43 ++++
 rtl/max_relu_unit.sv | 44 ++++
 rtl/max_pool_layer.sv | 140 ++++++++++++++
 tb/tb_max_pool_layer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions: DRAM region map, word widths, layer FSM encodings.
// Pure declarations, no latency.
// No flow control of its own.
package cnn_pkg;

  localparam int CNN_DATA_WIDTH    = 32;
  localparam int CNN_ADDR_WIDTH    = 18;

  localparam int WEIGHT_BASE       = 0;
  localparam int IFMAP_REGION_BASE = 65536;
  localparam int CONV_OUT_BASE     = 131072;
  localparam int POOL_OUT_BASE     = 196608;

  localparam int CH_BITS  = 4;
  localparam int POS_BITS = 5;
  localparam int PIX_BITS = CH_BITS + 2 * POS_BITS;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LAST  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } pool_state_t;

  // Word offset of one feature-map element inside its DRAM region.
  typedef struct packed {
    logic [CH_BITS-1:0]  c;
    logic [POS_BITS-1:0] y;
    logic [POS_BITS-1:0] x;
  } pix_addr_t;

  function automatic pix_addr_t make_pix_addr(input logic [CH_BITS-1:0] c,
                                              input logic [POS_BITS-1:0] y,
                                              input logic [POS_BITS-1:0] x);
    pix_addr_t p;
    p.c = c;
    p.y = y;
    p.x = x;
    return p;
  endfunction

endpackage

// File: rtl/max_relu_unit.sv
// Signed running maximum over a 2x2 window, with ReLU applied on the output register.
// Folds a word in the cycle it is presented; dout updates one cycle after out_load.
// No backpressure: caller asserts fold_vld only for words that were actually returned.
module max_relu_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  fold_vld,
  input  logic                  fold_first,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  out_load,
  output logic [DATA_WIDTH-1:0] dout
);

  logic signed [DATA_WIDTH-1:0] max_q;
  logic signed [DATA_WIDTH-1:0] din_s;
  logic signed [DATA_WIDTH-1:0] folded;

  assign din_s = din;

  // The first word of a window replaces whatever the previous window left behind.
  always_comb begin
    folded = max_q;
    if (fold_vld && (fold_first || (din_s > max_q))) begin
      folded = din_s;
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      max_q <= '0;
      dout  <= '0;
    end else begin
      if (fold_vld) begin
        max_q <= folded;
      end
      if (out_load) begin
        dout <= folded[DATA_WIDTH-1] ? '0 : folded;
      end
    end
  end

endmodule

// File: rtl/max_pool_layer.sv
// 2x2/stride-2 max pool + ReLU over a DRAM-resident feature map, result written back to DRAM.
// 6 cycles per output pixel when unstalled (4 reads, 1 fold, 1 write).
// dram_valid=0 holds the pending read or write request and all counters unchanged.
module max_pool_layer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH   = CNN_DATA_WIDTH,
  parameter int ADDR_WIDTH   = CNN_ADDR_WIDTH,
  parameter int NUM_CHNL     = 16,
  parameter int IFMAP_WIDTH  = 10,
  parameter int IFMAP_HEIGHT = 10,
  parameter int IFMAP_BASE   = CONV_OUT_BASE,
  parameter int OFMAP_BASE   = POOL_OUT_BASE
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  enable,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  done
);

  localparam int OBITS = POS_BITS - 1;

  pool_state_t        state_q, state_d;
  logic [1:0]         win_q;
  logic [CH_BITS-1:0] c_q;
  logic [OBITS-1:0]   oy_q, ox_q;
  logic               fold_vld_q, fold_first_q;

  logic      rd_acc, wr_acc;
  logic      ox_last, oy_last, c_last, frame_last;
  pix_addr_t rd_pix, wr_pix;

  assign rd_acc     = (state_q == ST_READ)  && dram_valid;
  assign wr_acc     = (state_q == ST_WRITE) && dram_valid;
  assign ox_last    = (ox_q == OBITS'(IFMAP_WIDTH / 2 - 1));
  assign oy_last    = (oy_q == OBITS'(IFMAP_HEIGHT / 2 - 1));
  assign c_last     = (c_q == CH_BITS'(NUM_CHNL - 1));
  assign frame_last = ox_last && oy_last && c_last;

  // Window position (dy,dx) is the window counter itself: (0,0),(0,1),(1,0),(1,1).
  assign rd_pix = make_pix_addr(c_q, {oy_q, win_q[1]}, {ox_q, win_q[0]});
  assign wr_pix = make_pix_addr(c_q, {1'b0, oy_q}, {1'b0, ox_q});

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_READ;
      ST_READ:  if (dram_valid && (win_q == 2'd3)) state_d = ST_LAST;
      ST_LAST:  state_d = ST_WRITE;
      ST_WRITE: if (dram_valid) state_d = frame_last ? ST_DONE : ST_READ;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dram_en_rd = 1'b0;
    dram_en_wr = 1'b0;
    addr_in    = '0;
    addr_out   = '0;
    done       = 1'b0;
    unique case (state_q)
      ST_READ: begin
        dram_en_rd = 1'b1;
        addr_in    = ADDR_WIDTH'(IFMAP_BASE) + ADDR_WIDTH'(rd_pix);
      end
      ST_WRITE: begin
        dram_en_wr = 1'b1;
        addr_out   = ADDR_WIDTH'(OFMAP_BASE) + ADDR_WIDTH'(wr_pix);
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      win_q        <= '0;
      c_q          <= '0;
      oy_q         <= '0;
      ox_q         <= '0;
      fold_vld_q   <= 1'b0;
      fold_first_q <= 1'b0;
    end else begin
      // Read data returns one cycle after acceptance, so the fold qualifiers trail by one.
      fold_vld_q   <= rd_acc;
      fold_first_q <= (win_q == 2'd0);
      if (state_q == ST_IDLE) begin
        win_q <= '0;
        c_q   <= '0;
        oy_q  <= '0;
        ox_q  <= '0;
      end
      if (rd_acc) begin
        win_q <= win_q + 2'd1;
      end
      if (wr_acc) begin
        if (ox_last) begin
          ox_q <= '0;
          if (oy_last) begin
            oy_q <= '0;
            c_q  <= c_last ? '0 : c_q + CH_BITS'(1);
          end else begin
            oy_q <= oy_q + OBITS'(1);
          end
        end else begin
          ox_q <= ox_q + OBITS'(1);
        end
      end
    end
  end

  max_relu_unit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_max_relu (
    .clk        (clk),
    .srstn      (srstn),
    .fold_vld   (fold_vld_q),
    .fold_first (fold_first_q),
    .din        (data_in),
    .out_load   (state_q == ST_LAST),
    .dout       (data_out)
  );

endmodule

// File: tb/tb_max_pool_layer.sv
// Directed bench for max_pool_layer: DRAM modelled as a word array answering one cycle after acceptance.
module tb_max_pool_layer;

  localparam int IBASE = 131072;
  localparam int OBASE = 196608;

  logic        clk = 1'b0;
  logic        srstn = 1'b0;
  logic        enable = 1'b0;
  logic        dram_valid = 1'b1;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic [17:0] addr_in;
  logic [17:0] addr_out;
  logic        dram_en_rd;
  logic        dram_en_wr;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [16384];

  always #5 clk = ~clk;

  max_pool_layer dut (
    .clk        (clk),
    .srstn      (srstn),
    .enable     (enable),
    .dram_valid (dram_valid),
    .data_in    (data_in),
    .data_out   (data_out),
    .addr_in    (addr_in),
    .addr_out   (addr_out),
    .dram_en_rd (dram_en_rd),
    .dram_en_wr (dram_en_wr),
    .done       (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; an accepted read returns its word in the following cycle, otherwise junk.
  task automatic tick();
    logic        acc;
    logic [17:0] a;
    acc = dram_en_rd && dram_valid;
    a   = addr_in;
    @(posedge clk);
    #1;
    if (acc) data_in = mem[a[13:0]];
    else     data_in = 32'h7EEE_EEEE;
  endtask

  function automatic logic [31:0] model_px(input int c, input int oy, input int ox);
    logic signed [31:0] m, v;
    m = mem[(c << 10) | ((2 * oy) << 5) | (2 * ox)];
    for (int i = 1; i < 4; i++) begin
      v = mem[(c << 10) | ((2 * oy + i / 2) << 5) | (2 * ox + i % 2)];
      if (v > m) m = v;
    end
    if (m < 0) m = 0;
    return m;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_addr_in"}, addr_in, 0);
    check({tag, "_addr_out"}, addr_out, 0);
    check({tag, "_en_rd"}, dram_en_rd, 0);
    check({tag, "_en_wr"}, dram_en_wr, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int t, wr, done_early, c, oy, ox;
    logic [31:0] first_vals [5];

    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    // c=0, oy=0: ox=0..4 windows at offsets {2ox, 2ox+1, 32+2ox, 33+2ox}
    mem[0] = 32'h0001_0000; mem[1] = 32'h0003_0000; mem[32] = 32'hFFFE_0000; mem[33] = 32'h0002_0000;
    mem[2] = 32'hFFFF_0000; mem[3] = 32'h8000_0000; mem[34] = 32'hFFFF_FFFF; mem[35] = 32'hFFF0_0000;
    mem[4] = 32'h8000_0000; mem[5] = 32'h8000_0000; mem[36] = 32'h8000_0000; mem[37] = 32'h8000_0000;
    mem[6] = 32'h8000_0000; mem[7] = 32'h7FFF_FFFF; mem[38] = 32'hFFFF_FFFF; mem[39] = 32'h0000_0005;
    mem[8] = 32'h0000_0001; mem[9] = 32'h0000_0002; mem[40] = 32'h0000_0003; mem[41] = 32'h0000_0004;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    srstn = 1'b1;
    tick();
    check("idle_no_rd", dram_en_rd, 0);

    // Stalled second read of the first window.
    enable = 1'b1;
    tick();
    enable = 1'b0;
    t = 1;
    check("stall_rd0_addr", addr_in, IBASE);
    tick();
    t++;
    dram_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_hold_addr", addr_in, IBASE + 1);
      check("stall_hold_en", dram_en_rd, 1);
      tick();
      t++;
    end
    check("stall_hold_addr_end", addr_in, IBASE + 1);
    dram_valid = 1'b1;
    while (!dram_en_wr && t < 50) begin
      tick();
      t++;
    end
    check("stall_px_cycles", t, 9);
    check("stall_px_addr", addr_out, OBASE);
    check("stall_px_data", data_out, 32'h0003_0000);

    // Run on to the write of (c=3,oy=2,ox=4) and reset in the middle of it.
    t = 0;
    while (!(dram_en_wr && addr_out == 18'(OBASE + (3 << 10) + (2 << 5) + 4)) && t < 700) begin
      tick();
      t++;
    end
    check("reach_px_3_2_4", dram_en_wr, 1);
    check("px_3_2_4_data", data_out, model_px(3, 2, 4));
    srstn = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    tick();
    srstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("midrst_no_wr", dram_en_wr, 0);
      check("midrst_no_rd", dram_en_rd, 0);
      tick();
    end

    // Full frame with enable held high the whole time.
    enable = 1'b1;
    t = 0;
    wr = 0;
    done_early = 0;
    while (wr < 400 && t < 3000) begin
      tick();
      t++;
      if (done) done_early++;
      if (dram_en_wr) begin
        c  = wr / 25;
        oy = (wr % 25) / 5;
        ox = wr % 5;
        if (wr < 5) first_vals[wr] = data_out;
        check("run_addr", addr_out, OBASE + (c << 10) + (oy << 5) + ox);
        check("run_data", data_out, model_px(c, oy, ox));
        check("run_timing", t, 6 * (wr + 1));
        wr++;
      end
    end
    check("run_write_count", wr, 400);
    check("run_no_early_done", done_early, 0);
    check("win_mixed", first_vals[0], 32'h0003_0000);
    check("win_all_neg", first_vals[1], 32'h0000_0000);
    check("win_min_int", first_vals[2], 32'h0000_0000);
    check("win_max_int", first_vals[3], 32'h7FFF_FFFF);
    check("win_max_last", first_vals[4], 32'h0000_0004);

    tick();
    check("done_pulse", done, 1);
    check("done_no_wr", dram_en_wr, 0);
    tick();
    check("done_one_cycle", done, 0);
    check("idle_after_done", dram_en_rd, 0);
    tick();
    check("rerun_from_idle_en", dram_en_rd, 1);
    check("rerun_from_idle_addr", addr_in, IBASE);
    enable = 1'b0;
    srstn = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
